// File: rtl/temp_ctrl_pkg.sv
// Shared types and defaults for the temperature sample sequencer.
package temp_ctrl_pkg;

    localparam int DW_DEF = 3;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } state_t;

endpackage

// File: rtl/temp_sample_ctrl_if.sv
// Sensor request/response bundle between the sequencer and the sensor front end.
// Handshake: the controller raises sns_req and holds it until the sensor presents
// sns_dato with sns_rdy=1 for one cycle; sns_rdy is only honoured while a request is open.
interface temp_sample_ctrl_if #(
    parameter int DW = 3
);
    logic          sns_req;
    logic          sns_rdy;
    logic [DW-1:0] sns_dato;

    modport master (output sns_req, input sns_rdy, input sns_dato);
    modport slave  (input sns_req, output sns_rdy, output sns_dato);
endinterface

// File: rtl/tick_gen.sv
// Free-running sample period counter; emits a one-cycle tick on its last count.
module tick_gen #(
    parameter int PERIOD = 100000
) (
    input  logic clk,
    input  logic EN,
    input  logic run,
    output logic tick
);
    localparam int            CW   = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!EN) begin
            cnt <= '0;
        end else if (!run || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);
endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic sampling sequencer: launches sensor requests, loads the answered code into
// the temperature register with a one-cycle strobe, and flags timeouts and overruns.
module temp_sample_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int PERIOD  = 100000,
    parameter int TIMEOUT = 1000,
    parameter int DW      = DW_DEF
) (
    input  logic                  clk,
    input  logic                  EN,
    input  logic                  run,
    input  logic                  clr_err,
    temp_sample_ctrl_if.master    sns,
    output logic                  leer,
    output logic [DW-1:0]         dato,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  overrun,
    output logic [CNT_W-1:0]      sample_cnt,
    output state_t                fsm_state
);
    localparam int            TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic             tick;
    logic             pending;
    logic [TW-1:0]    tcnt;
    state_t           state, state_next;
    logic [TW-1:0]    tcnt_next;
    logic [DW-1:0]    dato_next;
    logic [CNT_W-1:0] cnt_next;
    logic             err_set;
    logic             consume;

    tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk  (clk),
        .EN   (EN),
        .run  (run),
        .tick (tick)
    );

    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        dato_next  = dato;
        cnt_next   = sample_cnt;
        err_set    = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = REQ;
                    consume    = 1'b1;
                end
            end
            REQ: begin
                tcnt_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // A response on the final wait cycle still counts as on time.
                if (sns.sns_rdy) begin
                    dato_next  = sns.sns_dato;
                    state_next = LOAD;
                end else if (tcnt == TLAST) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            LOAD: begin
                cnt_next   = sample_cnt + CNT_W'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!EN) begin
            state       <= IDLE;
            tcnt        <= '0;
            pending     <= 1'b0;
            dato        <= '0;
            sample_cnt  <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_next;
            tcnt       <= tcnt_next;
            dato       <= dato_next;
            sample_cnt <= cnt_next;
            if (!run || consume) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
            // Setting an error takes priority over a simultaneous clear.
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
            if (tick && pending) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign sns.sns_req = (state == REQ) || (state == WAIT);
    assign leer        = (state == LOAD);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;
endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Bench for temp_sample_ctrl: PERIOD=8/TIMEOUT=4 main instance plus a TIMEOUT=32 instance for overrun.
module tb_temp_sample_ctrl;
    import temp_ctrl_pkg::*;

    localparam int PERIOD_A  = 8;
    localparam int TIMEOUT_A = 4;
    localparam int TIMEOUT_B = 32;

    logic clk = 1'b0;
    logic en, run, clr_err;

    temp_sample_ctrl_if #(.DW(3)) sif_a ();
    temp_sample_ctrl_if #(.DW(3)) sif_b ();

    logic       leer_a, busy_a, terr_a, ovr_a;
    logic [2:0] dato_a;
    logic [7:0] cnt_a;
    state_t     st_a;
    logic       leer_b, busy_b, terr_b, ovr_b;
    logic [2:0] dato_b;
    logic [7:0] cnt_b;
    state_t     st_b;

    int checks   = 0;
    int failures = 0;
    int pt       = 0;
    int last_launch;

    logic [2:0] exp_dato;
    logic [7:0] exp_cnt;
    logic       exp_err;

    temp_sample_ctrl #(.PERIOD(PERIOD_A), .TIMEOUT(TIMEOUT_A), .DW(3)) dut_a (
        .clk(clk), .EN(en), .run(run), .clr_err(clr_err), .sns(sif_a),
        .leer(leer_a), .dato(dato_a), .busy(busy_a), .timeout_err(terr_a),
        .overrun(ovr_a), .sample_cnt(cnt_a), .fsm_state(st_a)
    );

    temp_sample_ctrl #(.PERIOD(PERIOD_A), .TIMEOUT(TIMEOUT_B), .DW(3)) dut_b (
        .clk(clk), .EN(en), .run(run), .clr_err(clr_err), .sns(sif_b),
        .leer(leer_b), .dato(dato_b), .busy(busy_b), .timeout_err(terr_b),
        .overrun(ovr_b), .sample_cnt(cnt_b), .fsm_state(st_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        pt++;
    endtask

    task automatic wait_req(input bit sel_b, input int bound, output int n);
        n = 0;
        while (((sel_b ? sif_b.sns_req : sif_a.sns_req) !== 1'b1) && (n < bound)) begin
            step();
            n++;
        end
    endtask

    task automatic reset_all();
        en = 1'b0;
        step();
        step();
        exp_dato = '0;
        exp_cnt  = '0;
        exp_err  = 1'b0;
    endtask

    // Next request on instance A must come exactly one period after the previous one.
    task automatic next_launch_a();
        int n;
        wait_req(1'b0, 3 * PERIOD_A, n);
        checks++;
        if (sif_a.sns_req !== 1'b1 || (pt - last_launch) != PERIOD_A) begin
            failures++;
            $display("FAIL launch_spacing: got req=%0b after %0d cycles, expected req=1 after %0d",
                     sif_a.sns_req, pt - last_launch, PERIOD_A);
        end
        last_launch = pt;
    endtask

    // Sensor answers at edge (launch + d); d outside [2, TIMEOUT+1] must time out.
    task automatic run_txn(input int d, input logic [2:0] data);
        bit ld;
        int req_end, busy_end, last;
        ld       = (d >= 2) && (d <= TIMEOUT_A + 1);
        req_end  = ld ? d - 1 : TIMEOUT_A;
        busy_end = ld ? d : TIMEOUT_A;
        last     = ld ? d + 1 : ((d > TIMEOUT_A + 1) ? d : TIMEOUT_A + 1);
        for (int k = 0; k <= last; k++) begin
            sif_a.sns_rdy  = (k == d - 1);
            sif_a.sns_dato = (k == d - 1) ? data : 3'($urandom);
            checks++;
            if (sif_a.sns_req !== (k <= req_end)) begin
                failures++;
                $display("FAIL sns_req d=%0d k=%0d: got %0b expected %0b", d, k, sif_a.sns_req, (k <= req_end));
            end
            checks++;
            if (leer_a !== (ld && k == d)) begin
                failures++;
                $display("FAIL leer d=%0d k=%0d: got %0b expected %0b", d, k, leer_a, (ld && k == d));
            end
            checks++;
            if (busy_a !== (k <= busy_end)) begin
                failures++;
                $display("FAIL busy d=%0d k=%0d: got %0b expected %0b", d, k, busy_a, (k <= busy_end));
            end
            if (ld && k == d) begin
                checks++;
                if (dato_a !== data) begin
                    failures++;
                    $display("FAIL dato_at_leer d=%0d: got %0h expected %0h", d, dato_a, data);
                end
            end
            if (k < last) step();
        end
        sif_a.sns_rdy = 1'b0;
        if (ld) begin
            exp_dato = data;
            exp_cnt  = exp_cnt + 8'd1;
        end else begin
            exp_err = 1'b1;
        end
        checks++;
        if (dato_a !== exp_dato || cnt_a !== exp_cnt || terr_a !== exp_err) begin
            failures++;
            $display("FAIL txn_end d=%0d: got dato=%0h cnt=%0d err=%0b expected dato=%0h cnt=%0d err=%0b",
                     d, dato_a, cnt_a, terr_a, exp_dato, exp_cnt, exp_err);
        end
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (terr_a !== 1'b0) begin
            failures++;
            $display("FAIL clr_err: got timeout_err=%0b expected 0", terr_a);
        end
    endtask

    task automatic test_reset();
        int n;
        run = 1'b1;
        clr_err = 1'b0;
        sif_a.sns_rdy = 1'b0; sif_a.sns_dato = '0;
        sif_b.sns_rdy = 1'b0; sif_b.sns_dato = '0;
        reset_all();
        checks++;
        if ({sif_a.sns_req, leer_a, dato_a, busy_a, terr_a, ovr_a, cnt_a} !== 15'd0 || st_a !== IDLE) begin
            failures++;
            $display("FAIL reset_outputs: got req=%0b leer=%0b dato=%0h busy=%0b err=%0b ovr=%0b cnt=%0d st=%0d expected all 0",
                     sif_a.sns_req, leer_a, dato_a, busy_a, terr_a, ovr_a, cnt_a, st_a);
        end
        en = 1'b1;
        // Release edge is the first edge after this point; request follows PERIOD edges later.
        wait_req(1'b0, 3 * PERIOD_A, n);
        checks++;
        if (sif_a.sns_req !== 1'b1 || n != PERIOD_A + 1) begin
            failures++;
            $display("FAIL first_req: got req=%0b after %0d steps, expected req=1 after %0d", sif_a.sns_req, n, PERIOD_A + 1);
        end
        last_launch = pt;
    endtask

    task automatic test_normal();
        run_txn(2, 3'b101);
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL normal_cnt: got %0d expected 1", cnt_a);
        end
    endtask

    task automatic test_timeout();
        next_launch_a();
        run_txn(0, 3'b000);
        clear_errors();
    endtask

    task automatic test_last_wait();
        next_launch_a();
        run_txn(TIMEOUT_A + 1, 3'b011);
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 12; i++) begin
            next_launch_a();
            d = $urandom_range(0, TIMEOUT_A + 3);
            run_txn(d, 3'($urandom));
            if (exp_err && ($urandom_range(0, 1) == 1)) clear_errors();
        end
    endtask

    task automatic b_answer(input int d, input logic [2:0] data);
        for (int k = 0; k <= d; k++) begin
            sif_b.sns_rdy  = (k == d - 1);
            sif_b.sns_dato = (k == d - 1) ? data : 3'b000;
            if (k == 2 * PERIOD_A - 2 || k == 2 * PERIOD_A - 1) begin
                checks++;
                if (ovr_b !== (k == 2 * PERIOD_A - 1)) begin
                    failures++;
                    $display("FAIL overrun_edge k=%0d: got %0b expected %0b", k, ovr_b, (k == 2 * PERIOD_A - 1));
                end
            end
            if (k < d) step();
        end
        sif_b.sns_rdy = 1'b0;
        checks++;
        if (leer_b !== 1'b1 || dato_b !== data) begin
            failures++;
            $display("FAIL b_load: got leer=%0b dato=%0h expected leer=1 dato=%0h", leer_b, dato_b, data);
        end
    endtask

    // Ticks land at launch+7 and launch+15 during a 20-cycle answer: the second overruns and is
    // dropped, so one launch follows at launch+22, then ticks at +23 and +31 give +26 and +32.
    task automatic test_overrun();
        int n, r, r2;
        int exp_gap[3] = '{22, 4, 6};
        reset_all();
        en = 1'b1;
        wait_req(1'b1, 3 * PERIOD_A, n);
        r = pt;
        b_answer(20, 3'b110);
        for (int j = 0; j < 3; j++) begin
            r2 = pt;
            wait_req(1'b1, 4 * PERIOD_A, n);
            checks++;
            if (sif_b.sns_req !== 1'b1 || (pt - r) != exp_gap[j]) begin
                failures++;
                $display("FAIL overrun_launch%0d: got req=%0b at +%0d expected +%0d", j, sif_b.sns_req, pt - r, exp_gap[j]);
            end
            r = pt;
            if (j < 2) b_answer(2, 3'(j + 1));
            if (r2 < 0) r = pt;
        end
        checks++;
        if (ovr_b !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %0b expected 1", ovr_b);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (ovr_b !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %0b expected 0", ovr_b);
        end
    endtask

    task automatic test_abort();
        int n;
        bit saw;
        reset_all();
        en = 1'b1;
        wait_req(1'b0, 3 * PERIOD_A, n);
        step();
        step();
        en = 1'b0;
        sif_a.sns_rdy  = 1'b1;
        sif_a.sns_dato = 3'b111;
        step();
        sif_a.sns_rdy = 1'b0;
        checks++;
        if (st_a !== IDLE || sif_a.sns_req !== 1'b0 || leer_a !== 1'b0 || busy_a !== 1'b0 ||
            dato_a !== 3'd0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL abort: got st=%0d req=%0b leer=%0b busy=%0b dato=%0h cnt=%0d expected all 0",
                     st_a, sif_a.sns_req, leer_a, busy_a, dato_a, cnt_a);
        end
        en  = 1'b1;
        run = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 3 * PERIOD_A; k++) begin
            step();
            if (sif_a.sns_req === 1'b1 || leer_a === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL run_off: got activity=%0b expected 0", saw);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_last_wait();
        test_random();
        test_overrun();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
